// File: rtl/glitch_sequencer.sv
// Glitch program sequencer: walks a ROM of 12-bit instructions, sending bytes,
// waiting delay-table counts and firing glitch pulses until a halt condition.
module glitch_sequencer #(
  parameter int unsigned PROG_LEN   = 14,
  parameter int unsigned NUM_DELAYS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  instr_pt,
  input  logic [11:0] instr,
  output logic [7:0]  delay_num,
  input  logic [31:0] delay_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        glitch_out,
  output logic        busy,
  output logic        done,
  output logic        halted
);

  localparam logic [7:0] ProgLen   = 8'(PROG_LEN);
  localparam logic [7:0] NumDelays = 8'(NUM_DELAYS);

  localparam logic [1:0] OpTx     = 2'b00;
  localparam logic [1:0] OpGlitch = 2'b01;
  localparam logic [1:0] OpDelay  = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StFetch, StTx, StDelayLoad, StDelay, StGlitch, StEnd
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  delay_num_q, delay_num_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        glitch_q, glitch_d;
  logic        halted_q, halted_d;
  logic [31:0] cnt_q, cnt_d;

  logic [1:0]  op;
  logic        ins_valid;
  logic [7:0]  ins_data;
  logic [31:0] dly_load;
  logic        unused_instr;

  assign op           = instr[11:10];
  assign ins_valid    = instr[9];
  assign ins_data     = instr[8:1];
  assign unused_instr = instr[0];

  // Out-of-table indices behave as a zero-length delay.
  assign dly_load = (delay_num_q >= NumDelays) ? 32'd0 : delay_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= 8'd0;
      delay_num_q <= 8'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      glitch_q    <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      delay_num_q <= delay_num_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      glitch_q    <= glitch_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    delay_num_d = delay_num_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    glitch_d    = glitch_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;
    if (abort) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      glitch_d   = 1'b0;
      cnt_d      = 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc_d     = 8'd0;
            halted_d = 1'b0;
            state_d  = StFetch;
          end
        end
        StFetch: begin
          // pc 255 is terminal so the counter can never wrap.
          if (pc_q >= ProgLen || pc_q == 8'hFF || !ins_valid) begin
            state_d = StEnd;
          end else if (op == OpTx) begin
            tx_data_d  = ins_data;
            tx_valid_d = 1'b1;
            state_d    = StTx;
          end else if (op == OpDelay) begin
            delay_num_d = ins_data;
            state_d     = StDelayLoad;
          end else if (op == OpGlitch) begin
            if (ins_data == 8'hFF) begin
              state_d = StEnd;
            end else if (ins_data == 8'h00) begin
              pc_d = pc_q + 8'd1;
            end else begin
              cnt_d    = {24'd0, ins_data};
              glitch_d = 1'b1;
              state_d  = StGlitch;
            end
          end else begin
            state_d = StEnd;
          end
        end
        StTx: begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            pc_d       = pc_q + 8'd1;
            state_d    = StFetch;
          end
        end
        StDelayLoad: begin
          cnt_d = dly_load;
          if (dly_load == 32'd0) begin
            pc_d    = pc_q + 8'd1;
            state_d = StFetch;
          end else begin
            state_d = StDelay;
          end
        end
        StDelay, StGlitch: begin
          if (cnt_q <= 32'd1) begin
            cnt_d    = 32'd0;
            glitch_d = 1'b0;
            pc_d     = pc_q + 8'd1;
            state_d  = StFetch;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        StEnd: begin
          halted_d = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StEnd);
    instr_pt   = pc_q;
    delay_num  = delay_num_q;
    tx_data    = tx_data_q;
    tx_valid   = tx_valid_q;
    glitch_out = glitch_q;
    halted     = halted_q;
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: ROM model, transmit-byte scoreboard and
// per-run cycle statistics sampled on the falling clock edge.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, tx_ready;
  logic [7:0]  instr_pt, delay_num, tx_data;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic        tx_valid, glitch_out, busy, done, halted;

  logic [11:0] rom  [256];
  logic [31:0] dtab [256];
  assign instr     = rom[instr_pt];
  assign delay_len = dtab[delay_num];

  int n_tests, n_fail;
  logic [7:0] sb[$];
  int busy_cyc, done_cyc, valid_cyc, gl_run, gl_last, gl_pulses, hs_cnt, stable;

  always #5 clk = ~clk;

  glitch_sequencer #(.PROG_LEN(14), .NUM_DELAYS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .instr_pt   (instr_pt),
    .instr      (instr),
    .delay_num  (delay_num),
    .delay_len  (delay_len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .glitch_out (glitch_out),
    .busy       (busy),
    .done       (done),
    .halted     (halted)
  );

  function automatic logic [11:0] ins(input logic [1:0] op, input logic [7:0] d);
    return {op, 1'b1, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cyc = 0; done_cyc = 0; valid_cyc = 0;
    gl_run = 0; gl_last = 0; gl_pulses = 0; hs_cnt = 0;
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 12'h000;
      dtab[i] = 32'd0;
    end
  endtask

  // Handshake is judged on the values the coming posedge will sample.
  task automatic tick();
    logic [8:0] e;
    if (tx_valid && tx_ready) begin
      if (sb.size() > 0) e = {1'b1, sb.pop_front()};
      else e = 9'h000;
      hs_cnt++;
      check("tx_byte", 64'({1'b1, tx_data}), 64'(e));
    end
    @(posedge clk);
    @(negedge clk);
    if (busy) busy_cyc++;
    if (done) done_cyc++;
    if (tx_valid) valid_cyc++;
    if (glitch_out) gl_run++;
    else if (gl_run != 0) begin
      gl_last = gl_run;
      gl_pulses++;
      gl_run = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_idle(input string tag);
    for (int k = 0; k < 20000 && busy; k++) tick();
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    load_clear();
    clear_stats();
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({instr_pt, delay_num, tx_data, tx_valid, glitch_out,
                                busy, done, halted}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two bytes then HALT, transmitter always ready.
    rom[0] = ins(2'd0, 8'h84); rom[1] = ins(2'd0, 8'h01); rom[2] = ins(2'd3, 8'h00);
    sb.push_back(8'h84); sb.push_back(8'h01);
    clear_stats(); pulse_start(); run_idle("a_idle");
    check("a_busy_cycles", 64'(busy_cyc), 64'd6);
    check("a_done_pulses", 64'(done_cyc), 64'd1);
    check("a_halted", 64'(halted), 64'd1);
    check("a_valid_cycles", 64'(valid_cyc), 64'd2);
    check("a_handshakes", 64'(hs_cnt), 64'd2);
    check("a_sb_empty", 64'(sb.size()), 64'd0);

    // Transmitter stalls for 10 cycles.
    load_clear();
    rom[0] = ins(2'd0, 8'hA4); rom[1] = ins(2'd3, 8'h00);
    sb.push_back(8'hA4);
    tx_ready = 1'b0;
    clear_stats(); pulse_start();
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_valid && tx_data == 8'hA4 && instr_pt == 8'd0 && busy) stable++;
    end
    check("b_stable_cycles", 64'(stable), 64'd10);
    check("b_no_early_hs", 64'(hs_cnt), 64'd0);
    check("b_halted_cleared", 64'(halted), 64'd0);
    tx_ready = 1'b1;
    tick();
    check("b_pc_advance", 64'({instr_pt, tx_valid}), 64'({8'd1, 1'b0}));
    run_idle("b_idle");
    check("b_done", 64'(done_cyc), 64'd1);
    check("b_sb_empty", 64'(sb.size()), 64'd0);

    // Long delay from table entry 0.
    load_clear();
    dtab[0] = 32'h1F40;
    rom[0] = ins(2'd2, 8'd0); rom[1] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start(); run_idle("c_idle");
    check("c_delay_8000", 64'(busy_cyc), 64'd8004);

    // Out-of-table index and zero-length entry both skip the wait.
    load_clear();
    dtab[5] = 32'd100; dtab[1] = 32'd0;
    rom[0] = ins(2'd2, 8'd5); rom[1] = ins(2'd2, 8'd1); rom[2] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start(); run_idle("d_idle");
    check("d_busy_cycles", 64'(busy_cyc), 64'd6);
    check("d_pc_delay_num", 64'({instr_pt, delay_num}), 64'({8'd2, 8'd1}));

    // 242-cycle glitch pulse.
    load_clear();
    rom[0] = ins(2'd1, 8'hF2); rom[1] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start(); run_idle("f_idle");
    check("f_glitch_len", 64'(gl_last), 64'd242);
    check("f_glitch_pulses", 64'(gl_pulses), 64'd1);
    check("f_busy_cycles", 64'(busy_cyc), 64'd245);

    // Glitch 0xFF is a halt marker; the TX after it must never run.
    load_clear();
    rom[0] = ins(2'd1, 8'hFF); rom[1] = ins(2'd0, 8'h55);
    clear_stats(); pulse_start(); run_idle("g_idle");
    check("g_no_pulse", 64'(gl_pulses), 64'd0);
    check("g_done_pc", 64'({done_cyc[7:0], instr_pt}), 64'({8'd1, 8'd0}));
    check("g_busy_cycles", 64'(busy_cyc), 64'd2);

    // Glitch 0 is a no-op.
    load_clear();
    rom[0] = ins(2'd1, 8'h00); rom[1] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start(); run_idle("h_idle");
    check("h_no_pulse", 64'(gl_pulses), 64'd0);
    check("h_pc_busy", 64'({instr_pt, busy_cyc[7:0]}), 64'({8'd1, 8'd3}));

    // Full program with an invalid instruction at pc 6.
    load_clear();
    for (int i = 0; i < 14; i++) rom[i] = ins(2'd0, 8'(i + 16));
    rom[6][9] = 1'b0;
    for (int i = 0; i < 6; i++) sb.push_back(8'(i + 16));
    clear_stats(); pulse_start(); run_idle("i_idle");
    check("i_stop_pc", 64'(instr_pt), 64'd6);
    check("i_done", 64'(done_cyc), 64'd1);
    check("i_handshakes", 64'(hs_cnt), 64'd6);

    // Program running past PROG_LEN.
    load_clear();
    for (int i = 0; i < 15; i++) rom[i] = ins(2'd0, 8'(i + 32));
    for (int i = 0; i < 14; i++) sb.push_back(8'(i + 32));
    clear_stats(); pulse_start(); run_idle("j_idle");
    check("j_end_pc", 64'(instr_pt), 64'd14);
    check("j_done", 64'(done_cyc), 64'd1);
    check("j_busy_cycles", 64'(busy_cyc), 64'd30);
    check("j_sb_empty", 64'(sb.size()), 64'd0);

    // Abort on the 50th glitch cycle.
    load_clear();
    rom[0] = ins(2'd1, 8'hF2); rom[1] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start();
    repeat (50) tick();
    check("k_glitch_run", 64'(gl_run), 64'd50);
    abort = 1'b1; tick(); abort = 1'b0;
    check("k_abort_outs", 64'({glitch_out, tx_valid, busy, done}), 64'd0);
    repeat (3) tick();
    check("k_no_done", 64'({done_cyc[7:0], 7'd0, halted, 7'd0, busy}), 64'd0);
    check("k_pulse_len", 64'(gl_last), 64'd50);

    // Abort mid-delay, then restart from pc 0.
    load_clear();
    dtab[2] = 32'd40;
    rom[0] = ins(2'd0, 8'h11); rom[1] = ins(2'd2, 8'd2);
    rom[2] = ins(2'd1, 8'hF2); rom[3] = ins(2'd3, 8'h00);
    sb.push_back(8'h11);
    clear_stats(); pulse_start();
    repeat (10) tick();
    check("l_in_delay_pc", 64'({instr_pt, busy}), 64'({8'd1, 1'b1}));
    abort = 1'b1; tick(); abort = 1'b0;
    check("l_abort_outs", 64'({instr_pt, glitch_out, tx_valid, busy, done}),
          64'({8'd1, 4'd0}));
    check("l_no_done", 64'(done_cyc), 64'd0);
    sb.push_back(8'h11);
    clear_stats(); pulse_start(); run_idle("l_idle");
    check("l_restart_busy", 64'(busy_cyc), 64'd289);
    check("l_restart_glitch", 64'(gl_last), 64'd242);
    check("l_restart_done", 64'({done_cyc[7:0], 7'd0, halted}), 64'({8'd1, 8'd1}));
    check("l_sb_empty", 64'(sb.size()), 64'd0);

    // start and abort together: abort wins.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("m_start_abort", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a delay.
    load_clear();
    dtab[0] = 32'd8000;
    rom[0] = ins(2'd2, 8'd0); rom[1] = ins(2'd3, 8'h00);
    clear_stats(); pulse_start();
    repeat (20) tick();
    check("n_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("n_async_reset", 64'({instr_pt, delay_num, tx_data, tx_valid, glitch_out,
                                busy, done, halted}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_clear();
    rom[0] = ins(2'd0, 8'h84); rom[1] = ins(2'd0, 8'h01); rom[2] = ins(2'd3, 8'h00);
    sb.push_back(8'h84); sb.push_back(8'h01);
    clear_stats(); pulse_start(); run_idle("n_idle");
    check("n_after_reset", 64'({hs_cnt[7:0], done_cyc[7:0], busy_cyc[7:0]}),
          64'({8'd2, 8'd1, 8'd6}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
